spi_slave_ctrl: RTL
===================

// Module: spi_slave_ctrl
// PURPOSE
//  SPI slave controller for the spi_sync domain. It passes the external SCLK, CS_n and
//  MOSI pins through 3-FF edge synchronizers into sysClk_i and sequences bit shifting
//  from the synchronized edge strobes. It presents received words on a valid/ready port
//  and accepts transmit words on a valid/ready port. Sits between the pad-level SPI pins
//  and the system-side register/bus logic.
// PARAMETERS
//  DATA_WIDTH  8  bits per SPI word (>=2)
//  CPOL        0  SCLK idle level
//  CPHA        0  0: sample on leading edge; 1: sample on trailing edge
// PORTS
//  sysClk_i       in   1   system clock; all logic in this domain
//  reset_ni       in   1   synchronous active-low reset
//  spiClk_i       in   1   SCLK pin, asynchronous
//  spiCs_ni       in   1   chip select pin, active-low, asynchronous
//  mosi_i         in   1   MOSI pin, asynchronous
//  miso_o         out  1   MISO data = tx_shift[DATA_WIDTH-1]
//  miso_oe_o      out  1   MISO output enable (high while CS is asserted, synchronized)
//  tx_data_i      in   DW  transmit word
//  tx_valid_i     in   1   transmit word valid
//  tx_ready_o     out  1   transmit holding buffer empty
//  rx_data_o      out  DW  last complete received word
//  rx_valid_o     out  1   rx_data_o valid; held until rx_ready_i
//  rx_ready_i     in   1   consumer accepts rx_data_o
//  rx_overrun_o   out  1   sticky: a word completed while rx_valid_o was high
//  tx_underrun_o  out  1   1-cycle pulse: reload found the tx buffer empty
//  rx_abort_o     out  1   1-cycle pulse: CS rose with 0 < bit_cnt < DW
//  busy_o         out  1   FSM not in IDLE
// BEHAVIOUR
//  - Reset (reset_ni=0 at a sysClk_i edge): all outputs 0 except tx_ready_o=1. FSM=IDLE,
//    bit_cnt=0, shift registers=0, synchronizer stages=0. Applies mid-transfer too.
//  - Sync: sclk/cs/mosi each pass through 3 FFs. Edge strobes come from stages 2/1; data
//    comes from stage 1, so MOSI is aligned with the SCLK edge strobe.
//  - Edge map: leading = rising if CPOL=0, else falling. sample = leading if CPHA=0,
//    else trailing. shift = the other edge.
//  - Requirement: sysClk_i >= 8x SCLK. Minimum CS_n-low to first SCLK edge is 4 sysClk.
//  - tx buffer: a write occurs when tx_valid_i && tx_ready_o; tx_ready_o then drops.
//    Consuming the word at LOAD or reload sets tx_ready_o=1.
//    If a write and a consume happen in the same cycle, the consume takes the old word
//    and the new word is stored.
//  - FSM IDLE: on cs falling strobe -> LOAD.
//  - FSM LOAD (1 cycle): tx_shift <= buffer if full, else 0 with a tx_underrun_o pulse.
//    bit_cnt=0, first=1 -> SHIFT.
//  - FSM SHIFT, sample strobe: rx_shift <= {rx_shift[DW-2:0], mosi_s}; bit_cnt++.
//  - FSM SHIFT, shift strobe: if CPHA=1 && first, first<=0 and no shift (MSB already
//    shown). Otherwise, if bit_cnt==DW then reload tx_shift (buffer or 0 + underrun) and
//    set bit_cnt=0; else tx_shift <<= 1.
//  - Word complete: on the sample strobe where bit_cnt becomes DW, on the next sysClk
//    edge rx_data_o <= word and rx_valid_o <= 1. If rx_valid_o was already 1 and not
//    accepted that cycle, set rx_overrun_o and overwrite.
//    rx_valid_o clears on rx_valid_o && rx_ready_i unless a new word lands that cycle.
//  - CPHA=1 last word: its reload happens at the next leading edge, which has first=1
//    semantics.
//  - Latency: rx_valid_o rises 3 sysClk edges after the final sample edge is first
//    captured by stage 0.
//  - CS rising strobe in any state -> IDLE next cycle. Partial word discarded, bit_cnt=0,
//    rx_abort_o pulses if 0<bit_cnt<DW, miso_oe_o=0. An unconsumed tx buffer word is kept.
//  - CS rise and sample edge in the same cycle: CS wins (the word is not completed).
//  - rx_overrun_o clears on the next CS falling strobe or on reset.
//  - bit_cnt width = $clog2(DW+1); no wrap past DW.
// STRUCTURE
//  - spi_pkg: typedef enum logic [1:0] {IDLE, LOAD, SHIFT} spi_state_t; mode/edge
//    helper functions.
//  - Sub-module cdc_edge_sync: 3-FF synchronizer with sync/rising/falling outputs,
//    instantiated for SCLK, CS_n and MOSI (MOSI edge outputs unused).
//  - Top: FSM, bit counter, rx/tx shift regs, tx holding buffer, rx output reg.
// TESTING
//  - Mode 0, tx preloaded 0x3C, MOSI 0xA5 -> rx_data_o=0xA5 with rx_valid_o held;
//    MISO=0,0,1,1,1,1,0,0.
//  - Two back-to-back words 0x01, 0x80 with rx_ready_i=0 -> rx_overrun_o=1,
//    rx_data_o=0x80.
//  - CS_n rises after 5 bits -> rx_abort_o pulse, no rx_valid_o; the next 0x77 transfer
//    is received correctly.
//  - No tx write before CS_n falls -> tx_underrun_o pulse, MISO all 0; the rx word is
//    still correct.
//  - CPOL=1, CPHA=1: MOSI 0x5A, tx 0xC3 -> rx_data_o=0x5A, MISO bits 1,1,0,0,0,0,1,1.
//  - reset_ni=0 for 1 cycle mid-word -> reset values next cycle; after CS_n
//    re-asserts, a 0xF0 transfer is received cleanly.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared state type and SPI mode/edge helpers for the spi_sync domain.
package spi_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2
  } spi_state_t;

  // Leading SCLK edge is rising when the clock idles low.
  function automatic logic leading_is_rise(input logic cpol);
    return ~cpol;
  endfunction

  // Sample on the leading edge for CPHA=0, on the trailing edge for CPHA=1.
  function automatic logic sample_is_rise(input logic cpol, input logic cpha);
    return leading_is_rise(cpol) ^ cpha;
  endfunction

endpackage

// File: rtl/spi_slave_ctrl_if.sv
// Pin-side SPI signals plus rx/tx valid/ready ports of the SPI slave controller.
interface spi_slave_ctrl_if #(
  parameter int unsigned DATA_WIDTH = 8
);
  logic                  spiClk_i;
  logic                  spiCs_ni;
  logic                  mosi_i;
  logic                  miso_o;
  logic                  miso_oe_o;
  logic [DATA_WIDTH-1:0] tx_data_i;
  logic                  tx_valid_i;
  logic                  tx_ready_o;
  logic [DATA_WIDTH-1:0] rx_data_o;
  logic                  rx_valid_o;
  logic                  rx_ready_i;
  logic                  rx_overrun_o;
  logic                  tx_underrun_o;
  logic                  rx_abort_o;
  logic                  busy_o;

  modport slave (
    input  spiClk_i, spiCs_ni, mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    output miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, rx_abort_o, busy_o
  );

  modport master (
    output spiClk_i, spiCs_ni, mosi_i, tx_data_i, tx_valid_i, rx_ready_i,
    input  miso_o, miso_oe_o, tx_ready_o, rx_data_o, rx_valid_o,
           rx_overrun_o, tx_underrun_o, rx_abort_o, busy_o
  );

endinterface

// File: rtl/cdc_edge_sync.sv
// 3-FF synchronizer for an asynchronous pin; stage 1 is the synchronized level,
// stages 1/2 form the rising/falling edge strobes.
module cdc_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic sync,
  output logic rise_c,
  output logic fall_c
);

  logic [2:0] stage;

  always_ff @(posedge clk) begin
    if (!rst_n) stage <= '0;
    else        stage <= {stage[1:0], din};
  end

  assign sync   = stage[1];
  assign rise_c = stage[1] & ~stage[2];
  assign fall_c = ~stage[1] & stage[2];

endmodule

// File: rtl/spi_slave_ctrl.sv
// SPI slave controller: synchronizes SCLK/CS_n/MOSI into sysClk_i and shifts words
// between the pins and the rx/tx valid/ready ports.
module spi_slave_ctrl
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter logic        CPOL       = 1'b0,
  parameter logic        CPHA       = 1'b0
) (
  input logic             sysClk_i,
  input logic             reset_ni,
  spi_slave_ctrl_if.slave bus
);

  localparam int unsigned      DW          = DATA_WIDTH;
  localparam int unsigned      CNT_W       = $clog2(DW + 1);
  localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DW - 1);
  localparam logic [CNT_W-1:0] CNT_FULL    = CNT_W'(DW);
  localparam logic             SAMPLE_RISE = sample_is_rise(CPOL, CPHA);

  logic sclk_sync_unused, sclk_rise, sclk_fall;
  logic cs_sync_unused, cs_rise, cs_fall;
  logic mosi_s, mosi_rise_unused, mosi_fall_unused;

  cdc_edge_sync u_sclk_sync (.clk(sysClk_i), .rst_n(reset_ni), .din(bus.spiClk_i),
                             .sync(sclk_sync_unused), .rise_c(sclk_rise), .fall_c(sclk_fall));
  cdc_edge_sync u_cs_sync   (.clk(sysClk_i), .rst_n(reset_ni), .din(bus.spiCs_ni),
                             .sync(cs_sync_unused), .rise_c(cs_rise), .fall_c(cs_fall));
  cdc_edge_sync u_mosi_sync (.clk(sysClk_i), .rst_n(reset_ni), .din(bus.mosi_i),
                             .sync(mosi_s), .rise_c(mosi_rise_unused), .fall_c(mosi_fall_unused));

  spi_state_t       state, state_next;
  logic [CNT_W-1:0] bit_cnt;
  logic             first;
  logic [DW-1:0]    rx_shift, tx_shift, tx_buf, rx_data;
  logic             tx_ready, rx_valid, rx_overrun, tx_underrun, rx_abort;
  logic             miso_oe, busy, word_done_q;

  logic sample_c, shift_c, do_load, do_sample, do_shift;
  logic cnt_full_c, skip_c, reload_c, shift_one_c, consume_c, word_done_c, tx_write_c;

  // Next state and per-cycle action strobes; CS rising overrides everything.
  always_comb begin
    state_next = state;
    do_load    = 1'b0;
    do_sample  = 1'b0;
    do_shift   = 1'b0;
    sample_c   = SAMPLE_RISE ? sclk_rise : sclk_fall;
    shift_c    = SAMPLE_RISE ? sclk_fall : sclk_rise;
    if (cs_rise) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    if (cs_fall) state_next = LOAD;
        LOAD: begin
          do_load    = 1'b1;
          state_next = SHIFT;
        end
        SHIFT: begin
          do_sample = sample_c;
          do_shift  = shift_c;
        end
        default: state_next = IDLE;
      endcase
    end
  end

  // With CPHA=1 the first shift edge of a transfer only exposes the already-loaded MSB.
  assign cnt_full_c  = (bit_cnt == CNT_FULL);
  assign skip_c      = CPHA && first;
  assign reload_c    = do_shift && !skip_c && cnt_full_c;
  assign shift_one_c = do_shift && !skip_c && !cnt_full_c;
  assign consume_c   = do_load || reload_c;
  assign word_done_c = do_sample && (bit_cnt == CNT_LAST);
  assign tx_write_c  = bus.tx_valid_i && tx_ready;

  always_ff @(posedge sysClk_i) begin
    if (!reset_ni) state <= IDLE;
    else           state <= state_next;
  end

  always_ff @(posedge sysClk_i) begin
    if (!reset_ni) begin
      bit_cnt     <= '0;
      first       <= 1'b0;
      rx_shift    <= '0;
      tx_shift    <= '0;
      tx_buf      <= '0;
      rx_data     <= '0;
      tx_ready    <= 1'b1;
      rx_valid    <= 1'b0;
      rx_overrun  <= 1'b0;
      tx_underrun <= 1'b0;
      rx_abort    <= 1'b0;
      miso_oe     <= 1'b0;
      busy        <= 1'b0;
      word_done_q <= 1'b0;
    end else begin
      busy        <= (state_next != IDLE);
      tx_underrun <= consume_c && tx_ready;
      rx_abort    <= cs_rise && (bit_cnt != '0) && !cnt_full_c;
      word_done_q <= word_done_c;

      if (cs_fall)      miso_oe <= 1'b1;
      else if (cs_rise) miso_oe <= 1'b0;

      if (do_load)       first <= 1'b1;
      else if (skip_c && do_shift) first <= 1'b0;

      if (cs_rise || do_load || reload_c)   bit_cnt <= '0;
      else if (do_sample && !cnt_full_c)    bit_cnt <= bit_cnt + CNT_W'(1);

      if (do_sample) rx_shift <= {rx_shift[DW-2:0], mosi_s};

      // An empty holding buffer sends zeros for the whole word.
      if (consume_c)        tx_shift <= tx_ready ? '0 : tx_buf;
      else if (shift_one_c) tx_shift <= {tx_shift[DW-2:0], 1'b0};

      if (tx_write_c) begin
        tx_buf   <= bus.tx_data_i;
        tx_ready <= 1'b0;
      end else if (consume_c && !tx_ready) begin
        tx_ready <= 1'b1;
      end

      if (cs_fall) rx_overrun <= 1'b0;
      if (word_done_q) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
        if (rx_valid && !bus.rx_ready_i) rx_overrun <= 1'b1;
      end else if (rx_valid && bus.rx_ready_i) begin
        rx_valid <= 1'b0;
      end
    end
  end

  assign bus.miso_o        = tx_shift[DW-1];
  assign bus.miso_oe_o     = miso_oe;
  assign bus.tx_ready_o    = tx_ready;
  assign bus.rx_data_o     = rx_data;
  assign bus.rx_valid_o    = rx_valid;
  assign bus.rx_overrun_o  = rx_overrun;
  assign bus.tx_underrun_o = tx_underrun;
  assign bus.rx_abort_o    = rx_abort;
  assign bus.busy_o        = busy;

endmodule
